// File: rtl/list_pkg.sv
// Shared definitions for the list command front-end: opcodes, the
// command record layout and the controller FSM state encoding.
package list_pkg;

    // List opcodes as seen on cmd_op / op_sel
    localparam logic [2:0] OP_Read     = 3'd0;
    localparam logic [2:0] OP_Insert   = 3'd1;
    localparam logic [2:0] OP_Find_all = 3'd2;
    localparam logic [2:0] OP_Find_1st = 3'd3;
    localparam logic [2:0] OP_Sum      = 3'd4;
    localparam logic [2:0] OP_Sort_Asc = 3'd5;
    localparam logic [2:0] OP_Sort_Des = 3'd6;
    localparam logic [2:0] OP_Delete   = 3'd7;

    typedef logic [2:0] list_op_t;

    // Default-width command record. Parameterised blocks rebuild the same
    // field order {op, index, data, tag} at their own widths.
    localparam int LIST_DATA_WIDTH   = 8;
    localparam int LIST_LENGTH_WIDTH = 3;
    localparam int LIST_TAG_WIDTH    = 4;

    typedef struct packed {
        list_op_t                     op;
        logic [LIST_LENGTH_WIDTH-1:0] index;
        logic [LIST_DATA_WIDTH-1:0]   data;
        logic [LIST_TAG_WIDTH-1:0]    tag;
    } list_cmd_t;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/list_cmd_fifo.sv
// Synchronous command FIFO. Power-of-2 depth; read and write pointers
// carry one extra MSB so full and empty are told apart without a counter.
module list_cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even when a pop happens in the
    // same cycle; the producer only sees cmd_ready = !full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop
    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    // NOTE: the array has no reset; the pointers alone decide which entries
    // are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/list_cmd_ctrl.sv
// Command front-end for the list: buffers commands, issues them one at a
// time on op_sel/op_en, and returns tagged responses with a timeout guard.
module list_cmd_ctrl
    import list_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int TIMEOUT    = 1024,
    localparam int LENGTH_WIDTH = $clog2(LENGTH),
    localparam int COUNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [LENGTH_WIDTH-1:0]          cmd_index,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [TAG_WIDTH-1:0]             cmd_tag,
    output logic [2:0]                       op_sel,
    output logic                             op_en,
    output logic [LENGTH_WIDTH-1:0]          index_in,
    output logic [DATA_WIDTH-1:0]            data_in,
    input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] data_out,
    input  logic                             op_done,
    input  logic                             op_error,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data,
    output logic                             rsp_error,
    output logic                             rsp_timeout,
    output logic [2:0]                       rsp_op,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    output logic                             busy,
    output logic [COUNT_WIDTH-1:0]           fifo_count
);

    localparam int TIMER_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

    // Same field order as list_cmd_t, sized by this instance's parameters
    typedef struct packed {
        logic [2:0]              op;
        logic [LENGTH_WIDTH-1:0] index;
        logic [DATA_WIDTH-1:0]   data;
        logic [TAG_WIDTH-1:0]    tag;
    } cmd_t;

    localparam int CMD_WIDTH = $bits(cmd_t);

    cmd_t                   push_cmd;
    cmd_t                   head_cmd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [TAG_WIDTH-1:0]   issue_tag;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   issue_start;
    logic                   timer_last;

    assign push_cmd = '{op: cmd_op, index: cmd_index, data: cmd_data, tag: cmd_tag};

    list_cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready   = !fifo_full;
    assign issue_start = (state == ST_IDLE) && !fifo_empty;
    assign fifo_pop    = issue_start;
    assign timer_last  = (timer == TIMER_LAST);

    // op_en and rsp_valid decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock.
    assign op_en     = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    // Next-state selection; op_done outside ISSUE is ignored by construction
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fifo_empty)           state_nxt = ST_ISSUE;
            ST_ISSUE: if (op_done || timer_last) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready)             state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Issue registers: loaded from the FIFO head, stable for the whole ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sel    <= '0;
            index_in  <= '0;
            data_in   <= '0;
            issue_tag <= '0;
        end else if (issue_start) begin
            op_sel    <= head_cmd.op;
            index_in  <= head_cmd.index;
            data_in   <= head_cmd.data;
            issue_tag <= head_cmd.tag;
        end
    end

    // Timeout counter: 0 on the first ISSUE cycle, times out at TIMEOUT-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (issue_start) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= timer + 1'b1;
        end
    end

    // Response capture on completion or timeout; held untouched through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_op      <= '0;
            rsp_tag     <= '0;
        end else if (state == ST_ISSUE) begin
            if (op_done) begin
                rsp_data    <= data_out;
                rsp_error   <= op_error;
                rsp_timeout <= 1'b0;
                rsp_op      <= op_sel;
                rsp_tag     <= issue_tag;
            end else if (timer_last) begin
                rsp_data    <= '0;
                rsp_error   <= 1'b0;
                rsp_timeout <= 1'b1;
                rsp_op      <= op_sel;
                rsp_tag     <= issue_tag;
            end
        end
    end

endmodule

// File: tb/tb_list_cmd_ctrl.sv
// Bench for list_cmd_ctrl: a behavioural list model answers op_en, and a
// scoreboard of pushed commands predicts every issue and response.
module tb_list_cmd_ctrl;
    import list_pkg::*;

    localparam int DW  = 8;
    localparam int LEN = 8;
    localparam int LW  = 3;
    localparam int FD  = 4;
    localparam int TW  = 4;
    localparam int TO  = 16;
    localparam int OW  = LW + DW;

    typedef struct {
        logic [2:0]    op;
        logic [LW-1:0] idx;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } cmd_s;

    typedef struct {
        logic [2:0]    op;
        logic [TW-1:0] tag;
        logic [OW-1:0] data;
        logic          err;
        logic          to;
    } rsp_s;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [LW-1:0] cmd_index;
    logic [DW-1:0] cmd_data;
    logic [TW-1:0] cmd_tag;
    logic [2:0]    op_sel;
    logic          op_en;
    logic [LW-1:0] index_in;
    logic [DW-1:0] data_in;
    logic [OW-1:0] data_out;
    logic          op_done;
    logic          op_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_data;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [2:0]    rsp_op;
    logic [TW-1:0] rsp_tag;
    logic          busy;
    logic [2:0]    fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_s cmd_q[$];
    rsp_s exp_q[$];
    rsp_s log_q[$];
    int   lst[$];

    // environment knobs
    int   lat      = 3;
    logic lat_rand = 1'b0;
    logic hang_all = 1'b0;
    int   hang_pct = 0;
    logic rr_rand  = 1'b0;
    logic rr_level = 1'b1;

    // monitor state
    logic in_op    = 1'b0;
    logic seen_op  = 1'b0;
    logic cur_hang = 1'b0;
    int   cur_lat  = 1;
    int   en_cycles = 0;
    int   gap      = 0;
    logic prev_stall = 1'b0;
    cmd_s cur;
    rsp_s snap;

    list_cmd_ctrl #(
        .DATA_WIDTH (DW),
        .LENGTH     (LEN),
        .FIFO_DEPTH (FD),
        .TAG_WIDTH  (TW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_index   (cmd_index),
        .cmd_data    (cmd_data),
        .cmd_tag     (cmd_tag),
        .op_sel      (op_sel),
        .op_en       (op_en),
        .index_in    (index_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .op_done     (op_done),
        .op_error    (op_error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .rsp_op      (rsp_op),
        .rsp_tag     (rsp_tag),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural list: applies one operation to lst and returns its result
    task automatic list_exec(input cmd_s c, output logic [OW-1:0] d, output logic e);
        int n;
        int tmp;
        int hit;
        d = '0;
        e = 1'b0;
        n = lst.size();
        case (c.op)
            OP_Read: begin
                if (int'(c.idx) < n) d = OW'(lst[c.idx]);
                else e = 1'b1;
            end
            OP_Insert: begin
                if (n == LEN || int'(c.idx) > n) e = 1'b1;
                else lst.insert(int'(c.idx), int'(c.data));
            end
            OP_Find_all: begin
                tmp = 0;
                for (int i = 0; i < n; i++) if (lst[i] == int'(c.data)) tmp++;
                d = OW'(tmp);
            end
            OP_Find_1st: begin
                hit = -1;
                for (int i = n - 1; i >= 0; i--) if (lst[i] == int'(c.data)) hit = i;
                if (hit < 0) e = 1'b1;
                else d = OW'((hit << DW) | int'(c.data));
            end
            OP_Sum: begin
                tmp = 0;
                for (int i = 0; i < n; i++) tmp += lst[i];
                d = OW'(tmp);
            end
            OP_Sort_Asc, OP_Sort_Des: begin
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n - 1 - i; j++)
                        if ((c.op == OP_Sort_Asc) ? (lst[j] > lst[j+1]) : (lst[j] < lst[j+1])) begin
                            tmp = lst[j]; lst[j] = lst[j+1]; lst[j+1] = tmp;
                        end
            end
            default: begin // OP_Delete
                if (int'(c.idx) < n) lst.delete(int'(c.idx));
                else e = 1'b1;
            end
        endcase
    endtask

    // List model and scoreboard, evaluated between clock edges
    always @(negedge clk) begin
        logic [OW-1:0] d;
        logic          e;
        rsp_s          r;
        if (rst) begin
            op_done = 1'b0; op_error = 1'b0; data_out = '0;
            in_op = 1'b0; seen_op = 1'b0; prev_stall = 1'b0; gap = 0;
            cmd_q.delete(); exp_q.delete(); log_q.delete(); lst.delete();
        end else begin
            if (op_done) begin
                op_done = 1'b0;
                check("rsp_latency", rsp_valid, 1);
            end
            check("one_outstanding", op_en && rsp_valid, 0);
            if (op_en) begin
                if (!in_op) begin
                    if (seen_op) check("op_en_gap", gap >= 2, 1);
                    if (cmd_q.size() == 0) begin
                        check("issue_unexpected", 1, 0);
                        cur = '{default: '0};
                    end else begin
                        cur = cmd_q.pop_front();
                    end
                    check("issue_op", op_sel, cur.op);
                    check("issue_index", index_in, cur.idx);
                    check("issue_data", data_in, cur.data);
                    in_op = 1'b1;
                    en_cycles = 0;
                    cur_hang = hang_all || ($urandom_range(99) < hang_pct);
                    cur_lat = lat_rand ? int'($urandom_range(6, 1)) : lat;
                end
                en_cycles++;
                if (!cur_hang && en_cycles == cur_lat) begin
                    list_exec(cur, d, e);
                    data_out = d; op_error = e; op_done = 1'b1;
                    exp_q.push_back('{cur.op, cur.tag, d, e, 1'b0});
                end
            end else begin
                if (in_op) begin
                    check("op_en_cycles", en_cycles, cur_hang ? TO : cur_lat);
                    if (cur_hang) exp_q.push_back('{cur.op, cur.tag, '0, 1'b0, 1'b1});
                    in_op = 1'b0; seen_op = 1'b1; gap = 0;
                end
                gap++;
            end
            if (rsp_valid) begin
                if (prev_stall) begin
                    check("hold_data", rsp_data, snap.data);
                    check("hold_error", rsp_error, snap.err);
                    check("hold_timeout", rsp_timeout, snap.to);
                    check("hold_tag", rsp_tag, snap.tag);
                    check("hold_op", rsp_op, snap.op);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        check("rsp_op", rsp_op, r.op);
                        check("rsp_tag", rsp_tag, r.tag);
                        check("rsp_data", rsp_data, r.data);
                        check("rsp_error", rsp_error, r.err);
                        check("rsp_timeout", rsp_timeout, r.to);
                    end
                    log_q.push_back('{rsp_op, rsp_tag, rsp_data, rsp_error, rsp_timeout});
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    snap = '{rsp_op, rsp_tag, rsp_data, rsp_error, rsp_timeout};
                end
            end else begin
                if (prev_stall) check("hold_valid", rsp_valid, 1);
                prev_stall = 1'b0;
            end
        end
    end

    // Response consumer
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rr_rand ? ($urandom_range(3) != 0) : rr_level;
        end
    end

    // Offers one command for up to 'tries' cycles; returns at posedge+1
    task automatic push(input logic [2:0] op, input int idx, input int data,
                        input int tag, input int tries, output logic acc);
        cmd_s c;
        c.op = op; c.idx = LW'(idx); c.data = DW'(data); c.tag = TW'(tag);
        cmd_valid = 1'b1; cmd_op = c.op; cmd_index = c.idx; cmd_data = c.data; cmd_tag = c.tag;
        acc = 1'b0;
        for (int t = 0; t < tries && !acc; t++) begin
            if (cmd_ready) begin
                acc = 1'b1;
                cmd_q.push_back(c);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !in_op && exp_q.size() == 0) ok = 1'b1;
        end
        check(tag, ok, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n_acc;
        logic got;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_data = '0; cmd_tag = '0;
        op_done = 1'b0; op_error = 1'b0; data_out = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("reset_op_en", op_en, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_op_sel", op_sel, 0);
        rst = 1'b0;

        // Single Insert, list answers 3 cycles after op_en
        lat = 3; rr_level = 1'b1;
        push(OP_Insert, 0, 5, 1, 1, acc);
        check("t1_accept", acc, 1);
        check("t1_not_yet_issued", op_en, 0);
        check("t1_count_after_push", fifo_count, 1);
        @(posedge clk); #1;
        check("t1_issued", op_en, 1);
        check("t1_popped", fifo_count, 0);
        wait_idle("t1_idle", 50);
        check("t1_nrsp", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check("t1_tag", log_q[0].tag, 1);
            check("t1_op", log_q[0].op, OP_Insert);
            check("t1_err", log_q[0].err, 0);
        end

        // Back-to-back Insert 7, Insert 9, Read 1, Sum
        do_reset();
        lat = 2;
        push(OP_Insert, 0, 7, 2, 1, acc);
        push(OP_Insert, 1, 9, 3, 1, acc);
        push(OP_Read,   1, 0, 4, 1, acc);
        push(OP_Sum,    0, 0, 5, 1, acc);
        wait_idle("t2_idle", 100);
        check("t2_nrsp", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_order", log_q[i].tag, i + 2);
            check("t2_read", log_q[2].data, 9);
            check("t2_sum", log_q[3].data, 16);
        end

        // Stalled list: fill the FIFO, then let the head time out
        do_reset();
        hang_all = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(OP_Insert, 0, i + 1, i, 1, acc);
            check("t3_accept", acc, (i < 5) ? 1 : 0);
            if (acc) n_acc++;
        end
        check("t3_naccept", n_acc, 5);
        check("t3_full_count", fifo_count, FD);
        check("t3_full_ready", cmd_ready, 0);
        check("t3_busy", busy, 1);
        hang_all = 1'b0; lat = 1;
        wait_idle("t3_idle", 200);
        check("t3_nrsp", log_q.size(), 5);
        if (log_q.size() >= 2) begin
            check("t3_timeout", log_q[0].to, 1);
            check("t3_timeout_data", log_q[0].data, 0);
            check("t3_next_normal", log_q[1].to, 0);
        end

        // Read out of range with the consumer stalled for 5 cycles
        do_reset();
        lat = 2; rr_level = 1'b0;
        push(OP_Read, 7, 0, 5, 1, acc);
        push(OP_Sum,  0, 0, 6, 1, acc);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = rsp_valid;
        end
        check("t5_rsp_seen", got, 1);
        repeat (5) begin
            @(posedge clk); #1;
            check("t5_valid", rsp_valid, 1);
            check("t5_error", rsp_error, 1);
            check("t5_tag", rsp_tag, 5);
            check("t5_no_issue", op_en, 0);
            check("t5_queued", fifo_count, 1);
        end
        rr_level = 1'b1;
        wait_idle("t5_idle", 50);
        check("t5_nrsp", log_q.size(), 2);

        // Reset while an operation is in flight with two more queued
        do_reset();
        hang_all = 1'b1;
        push(OP_Insert, 0, 1, 1, 1, acc);
        push(OP_Insert, 0, 2, 2, 1, acc);
        push(OP_Insert, 0, 3, 3, 1, acc);
        check("t6_in_issue", op_en, 1);
        check("t6_queued", fifo_count, 2);
        #3;
        rst = 1'b1;
        #1;
        check("t6_op_en", op_en, 0);
        check("t6_count", fifo_count, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        hang_all = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_rsp", rsp_valid, 0);

        // Randomised traffic with random latency, timeouts and back-pressure
        do_reset();
        lat_rand = 1'b1; hang_pct = 8; rr_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            push(($urandom_range(2) == 0) ? OP_Insert : 3'($urandom_range(7)),
                 int'($urandom_range(LEN - 1)), int'($urandom_range(15)),
                 int'($urandom_range(15)), 200, acc);
            check("rand_accept", acc, 1);
        end
        wait_idle("rand_idle", 3000);
        check("rand_cmd_q_empty", cmd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
